// File: rtl/aes_req_arbiter.sv
// Two-requester round-robin front end for a shared AES encryption core.
// Launches one block at a time, waits for completion or timeout, and returns the result to its owner.
//
// state  | meaning
// IDLE   | arbitrate between requesters; winner sees ready
// LAUNCH | one-cycle core_start pulse; wait counter cleared
// WAIT   | wait for core_done, abort after TIMEOUT cycles
// RESP   | hold response until rsp_ready
module aes_req_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst1,
    input  logic         req0_valid,
    input  logic [127:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [127:0] req1_data,
    output logic         req1_ready,
    output logic         core_start,
    output logic [127:0] core_din,
    input  logic         core_done,
    input  logic [127:0] core_dout,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic [15:0]  ops_done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic          last_grant;
    logic [CW-1:0] wait_cnt;
    logic [127:0]  core_din_q;
    logic          rsp_id_q;
    logic [127:0]  rsp_data_q;
    logic          rsp_err_q;
    logic [15:0]   ops_cnt;

    logic grant0;
    logic grant1;
    logic in_idle;
    logic rsp_fire;

    // On a tie the requester not served last wins.
    assign grant0  = req0_valid && (!req1_valid || last_grant);
    assign grant1  = req1_valid && (!req0_valid || !last_grant);
    assign in_idle = (state == IDLE) && !rst1;

    assign req0_ready = in_idle && grant0;
    assign req1_ready = in_idle && grant1;
    assign core_start = (state == LAUNCH) && !rst1;
    assign rsp_valid  = (state == RESP) && !rst1;
    assign rsp_fire   = rsp_valid && rsp_ready;

    assign core_din = core_din_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign ops_done = ops_cnt;

    always_ff @(posedge clk) begin
        if (rst1) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            core_din_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        core_din_q <= grant0 ? req0_data : req1_data;
                        rsp_id_q   <= grant1;
                        last_grant <= grant1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A completion on the final allowed cycle still counts as success.
                    if (core_done) begin
                        rsp_data_q <= core_dout;
                        rsp_err_q  <= 1'b0;
                        state      <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst1) begin
            ops_cnt <= '0;
        end else if (rsp_fire && !rsp_err_q) begin
            ops_cnt <= ops_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a programmable-latency core model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_aes_req_arbiter;

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] D0 = 128'hA0A0A0A0_00000000_11111111_22222222;
    localparam logic [127:0] D1 = 128'hB1B1B1B1_33333333_44444444_55555555;

    logic         clk = 1'b0;
    logic         rst1;
    logic         req0_valid, req1_valid;
    logic [127:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         core_start;
    logic [127:0] core_din;
    logic         core_done;
    logic [127:0] core_dout;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [127:0] rsp_data;
    logic [15:0]  ops_done;

    int n_vec = 0;
    int n_err = 0;

    // core model: done pulses core_lat cycles after the start cycle; 0 = never
    int   core_lat = 0;
    int   mdl_cnt = 0;
    logic mdl_busy = 1'b0;
    logic mdl_done = 1'b0;
    logic spur = 1'b0;

    assign core_done = mdl_done | spur;
    assign core_dout = CT;

    always #5 clk = ~clk;

    aes_req_arbiter #(.TIMEOUT(64)) dut (
        .clk(clk), .rst1(rst1),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .core_start(core_start), .core_din(core_din),
        .core_done(core_done), .core_dout(core_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .ops_done(ops_done)
    );

    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (rst1) begin
            mdl_busy <= 1'b0;
        end else begin
            if (mdl_busy) begin
                if (mdl_cnt <= 1) begin
                    mdl_done <= 1'b1;
                    mdl_busy <= 1'b0;
                end else begin
                    mdl_cnt <= mdl_cnt - 1;
                end
            end
            if (core_start && core_lat > 0) begin
                if (core_lat == 1) begin
                    mdl_done <= 1'b1;
                end else begin
                    mdl_busy <= 1'b1;
                    mdl_cnt  <= core_lat - 1;
                end
            end
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Steps from the current negedge until rsp_valid is seen; returns steps taken.
    task automatic wait_rsp(input int limit, output int n);
        n = 0;
        while (!rsp_valid && n < limit) begin
            tick();
            #1;
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g;
        rst1 = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_data = PT;
        req1_data = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        #1;
        chk1("rst_req0_ready", req0_ready, 1'b0);
        chk1("rst_core_start", core_start, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_rsp_id", rsp_id, 1'b0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chkw("rst_rsp_data", rsp_data, '0);
        chkw("rst_core_din", core_din, '0);
        chk16("rst_ops_done", ops_done, 16'd0);

        // known-answer block, core answers 40 cycles after launch
        tick();
        rst1 = 1'b0;
        core_lat = 40;
        #1;
        chk1("kat_req0_ready", req0_ready, 1'b1);
        chk1("kat_req1_ready", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk1("kat_start", core_start, 1'b1);
        chkw("kat_core_din", core_din, PT);
        chk1("kat_ready_launch", req0_ready, 1'b0);
        tick();
        #1;
        chk1("kat_start_wait", core_start, 1'b0);
        wait_rsp(200, n);
        chkn("kat_latency", n, 40);
        chk1("kat_rsp_id", rsp_id, 1'b0);
        chk1("kat_rsp_err", rsp_err, 1'b0);
        chkw("kat_rsp_data", rsp_data, CT);
        chk16("kat_ops_before", ops_done, 16'd0);
        rsp_ready = 1'b1;
        tick();
        #1;
        chk1("kat_rsp_drop", rsp_valid, 1'b0);
        chk16("kat_ops_after", ops_done, 16'd1);

        // both requesters valid after reset: alternate 0,1,0,1 at minimum latency
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data = D0;
        req1_data = D1;
        core_lat = 1;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                tick();
                #1;
            end
            g = (i / 4) % 2;
            case (i % 4)
                0: begin
                    chk1("rr_ready0", req0_ready, g == 0);
                    chk1("rr_ready1", req1_ready, g == 1);
                    chk1("rr_idle_start", core_start, 1'b0);
                end
                1: begin
                    chk1("rr_start", core_start, 1'b1);
                    chkw("rr_core_din", core_din, (g == 0) ? D0 : D1);
                end
                2: begin
                    chk1("rr_start_once", core_start, 1'b0);
                    chk1("rr_no_rsp_yet", rsp_valid, 1'b0);
                end
                default: begin
                    chk1("rr_rsp_valid", rsp_valid, 1'b1);
                    chk1("rr_rsp_id", rsp_id, g == 1);
                    chkw("rr_rsp_data", rsp_data, CT);
                    chk1("rr_ready_resp", req0_ready | req1_ready, 1'b0);
                end
            endcase
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        #1;
        chk16("rr_ops", ops_done, 16'd4);

        // back-pressure: response held 10 cycles, pending request waits
        req0_valid = 1'b1;
        req0_data = PT;
        rsp_ready = 1'b0;
        #1;
        chk1("bp_accept", req0_ready, 1'b1);
        tick();
        #1;
        chk1("bp_start", core_start, 1'b1);
        tick();
        tick();
        #1;
        for (int k = 0; k < 10; k++) begin
            chk1("bp_rsp_valid", rsp_valid, 1'b1);
            chkw("bp_rsp_data", rsp_data, CT);
            chk1("bp_rsp_id", rsp_id, 1'b0);
            chk1("bp_no_start", core_start, 1'b0);
            chk1("bp_ready_low", req0_ready, 1'b0);
            tick();
            #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk1("bp_bubble", req0_ready, 1'b0);
        tick();
        #1;
        chk1("bp_rsp_drop", rsp_valid, 1'b0);
        chk1("bp_reaccept", req0_ready, 1'b1);
        chk16("bp_ops", ops_done, 16'd5);
        tick();
        req0_valid = 1'b0;
        #1;
        chk1("bp_start2", core_start, 1'b1);
        tick();
        tick();
        #1;
        chk1("bp_rsp2", rsp_valid, 1'b1);
        tick();
        #1;
        chk16("bp_ops2", ops_done, 16'd6);

        // core never answers: abort after 64 WAIT cycles
        core_lat = 0;
        req0_valid = 1'b1;
        rsp_ready = 1'b0;
        #1;
        chk1("to_accept", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        #1;
        chk1("to_start", core_start, 1'b1);
        tick();
        #1;
        wait_rsp(200, n);
        chkn("to_latency", n, 64);
        chk1("to_err", rsp_err, 1'b1);
        chkw("to_data", rsp_data, '0);
        chk16("to_ops_hold", ops_done, 16'd6);
        rsp_ready = 1'b1;
        tick();
        #1;
        chk16("to_ops_after", ops_done, 16'd6);

        // done on the last allowed WAIT cycle wins over the timeout
        core_lat = 64;
        req0_valid = 1'b1;
        rsp_ready = 1'b0;
        tick();
        req0_valid = 1'b0;
        tick();
        #1;
        wait_rsp(200, n);
        chkn("edge_latency", n, 64);
        chk1("edge_err", rsp_err, 1'b0);
        chkw("edge_data", rsp_data, CT);
        rsp_ready = 1'b1;
        tick();
        #1;
        chk16("edge_ops", ops_done, 16'd7);

        // reset in the middle of WAIT abandons the operation
        core_lat = 0;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        rst1 = 1'b1;
        req0_valid = 1'b1;
        #1;
        chk1("mr_no_start", core_start, 1'b0);
        chk1("mr_ready_gated", req0_ready, 1'b0);
        tick();
        #1;
        chk1("mr_rsp_valid", rsp_valid, 1'b0);
        chkw("mr_rsp_data", rsp_data, '0);
        chkw("mr_core_din", core_din, '0);
        chk16("mr_ops", ops_done, 16'd0);
        rst1 = 1'b0;
        req0_valid = 1'b0;
        tick();
        #1;
        chk1("mr_post_start", core_start, 1'b0);
        chk1("mr_post_rsp", rsp_valid, 1'b0);

        // spurious done during LAUNCH is ignored; real done 3 cycles after launch
        core_lat = 3;
        req0_valid = 1'b1;
        req0_data = D1;
        #1;
        chk1("sp_accept", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        spur = 1'b1;
        #1;
        chk1("sp_start", core_start, 1'b1);
        tick();
        spur = 1'b0;
        #1;
        chk1("sp_ignored", rsp_valid, 1'b0);
        wait_rsp(20, n);
        chkn("sp_latency", n, 3);
        chk1("sp_err", rsp_err, 1'b0);
        chkw("sp_data", rsp_data, CT);
        tick();
        #1;
        chk16("sp_ops", ops_done, 16'd1);

        // counter wrap: preload all-ones, lone requester 1 completes
        force dut.ops_cnt = 16'hFFFF;
        tick();
        release dut.ops_cnt;
        #1;
        chk16("wr_preload", ops_done, 16'hFFFF);
        core_lat = 1;
        req1_valid = 1'b1;
        req1_data = D0;
        #1;
        chk1("wr_ready1", req1_ready, 1'b1);
        chk1("wr_ready0", req0_ready, 1'b0);
        tick();
        req1_valid = 1'b0;
        #1;
        chkw("wr_core_din", core_din, D0);
        tick();
        tick();
        #1;
        chk1("wr_rsp_id", rsp_id, 1'b1);
        tick();
        #1;
        chk16("wr_ops_wrap", ops_done, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_req_arbiter.md
AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: maximum cycles waited for core_done before abort.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-003 SHALL have port rst1, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 each: requester has a 128-bit block to encrypt.
REQ-005 SHALL have ports req0_data/req1_data, input, 128 each: plaintext from requester 0/1.
REQ-006 SHALL have ports req0_ready/req1_ready, output, 1 each: request accepted when valid&ready in the same cycle.
REQ-007 SHALL have port core_start, output, 1: one-cycle launch pulse to the shared AES encryption core.
REQ-008 SHALL have port core_din, output, 128: plaintext presented to core; held stable from launch until the next acceptance.
REQ-009 SHALL have ports core_done, input, 1, and core_dout, input, 128: core completion pulse and ciphertext.
REQ-010 SHALL have ports rsp_valid, output, 1; rsp_ready, input, 1; rsp_id, output, 1; rsp_data, output, 128; rsp_err, output, 1: result to the originating requester.
REQ-011 SHALL have port ops_done, output, 16: count of successful (non-error) responses delivered.

Function
REQ-012 SHALL implement states IDLE, LAUNCH, WAIT, RESP.
REQ-013 IDLE: req_ready SHALL be high only for the arbitration winner; ready is low for both in all other states.
REQ-014 Arbitration SHALL be round-robin: single valid wins; both valid -> grant the requester not granted last; last_grant updates on acceptance only.
REQ-015 On acceptance SHALL latch data into core_din, winner into rsp_id, and go to LAUNCH.
REQ-016 LAUNCH: core_start SHALL be 1 for exactly this cycle; clear wait counter; go to WAIT.
REQ-017 WAIT: core_done=1 SHALL capture core_dout into rsp_data, rsp_err=0, go to RESP.
REQ-018 WAIT: counter SHALL increment each cycle without core_done; when counter = TIMEOUT-1 without core_done, SHALL set rsp_data=0, rsp_err=1, go to RESP.
REQ-019 core_done and TIMEOUT-1 in the same cycle: SHALL treat as success (done wins).
REQ-020 core_done outside WAIT (including LAUNCH) SHALL be ignored.
REQ-021 RESP: rsp_valid SHALL stay high with rsp_data/rsp_id/rsp_err stable until rsp_ready=1; then IDLE next cycle.
REQ-022 On rsp_valid&rsp_ready with rsp_err=0, ops_done SHALL increment by 1, wrapping 16'hFFFF -> 0.
REQ-023 New request valid during RESP handshake cycle SHALL be accepted no earlier than the following IDLE cycle (one-cycle bubble).
REQ-024 Minimum request-to-response latency: acceptance cycle + LAUNCH + 1 WAIT cycle -> rsp_valid 3 cycles after acceptance with immediate done.
REQ-025 Requests not granted SHALL remain pending unmodified; no requester is starved beyond one grant of the other.

Reset
REQ-026 rst1=1 SHALL force state IDLE, core_start=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_data=0, core_din=0, req ready outputs 0 during reset, ops_done=0, wait counter=0, last_grant=1 (requester 0 wins first tie).
REQ-027 Reset asserted in any state, including mid-WAIT or mid-RESP, SHALL abandon the operation with no response and no core_start in the reset cycle or following cycle unless a new request is accepted.

Verification
REQ-028 req0_data=128'h00112233445566778899aabbccddeeff, core model returns 128'h69c4e0d86a7b0430d8cdb78070b4c55a after 40 cycles -> rsp_valid, rsp_id=0, rsp_err=0, that data, ops_done=1.
REQ-029 Both requesters valid continuously after reset -> grant order 0,1,0,1; each core_start exactly one cycle; four responses with ids 0,1,0,1.
REQ-030 Core model never asserts done, TIMEOUT=64 -> rsp_valid 64 cycles after LAUNCH with rsp_err=1, rsp_data=0, ops_done unchanged.
REQ-031 rsp_ready held low 10 cycles in RESP -> rsp outputs stable, no core_start, req ready low; release -> IDLE, next request accepted.
REQ-032 rst1 pulsed during WAIT -> no response, all outputs at reset values; subsequent request completes normally; spurious core_done during LAUNCH ignored.
REQ-033 ops_done preloaded via 65535 successful ops -> next success wraps to 0.
